// File: rtl/addsub_pkg.sv
// Shared definitions for pipelined_addsub: operation encoding and saturation constants.
// Saturation logic that uses MAX_POS/MAX_NEG is only built with PIPELINED_ADDSUB_SAT_EN.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        SUB  = 2'b01,
        SADD = 2'b10,
        SSUB = 2'b11
    } op_e;

    localparam int unsigned MAX_W = 256;

    // Largest positive two's-complement value of width w, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] MAX_POS(input int unsigned w);
        MAX_POS = '0;
        for (int unsigned i = 0; i < w - 1; i++) begin
            MAX_POS[i] = 1'b1;
        end
    endfunction

    // Most negative two's-complement value of width w, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] MAX_NEG(input int unsigned w);
        MAX_NEG = '0;
        MAX_NEG[w-1] = 1'b1;
    endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead slice: sum for a given carry-in, plus group propagate/generate
// (both independent of carry-in) for the inter-group lookahead in the parent.
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             cin_i,
    output logic [GROUP-1:0] sum_o,
    output logic             p_o,
    output logic             g_o
);

    logic [GROUP-1:0] pb;
    logic [GROUP-1:0] gb;
    logic [GROUP-1:0] c;

    always_comb begin
        pb = a_i ^ b_i;
        gb = a_i & b_i;
        c = '0;
        c[0] = cin_i;
        for (int unsigned i = 1; i < GROUP; i++) begin
            c[i] = gb[i-1] | (pb[i-1] & c[i-1]);
        end
        sum_o = pb ^ c;
        p_o = &pb;
        g_o = 1'b0;
        for (int unsigned i = 0; i < GROUP; i++) begin
            g_o = gb[i] | (pb[i] & g_o);
        end
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Two-stage add/subtract with valid/ready handshake: S1 adds the low half, S2 the high half.
// Define PIPELINED_ADDSUB_SAT_EN to enable saturation for SADD/SSUB.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl,
    output logic             sat,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NG   = HALF / GROUP;

    op_e              op_in;
    logic             sub_in;
    logic [WIDTH-1:0] b_eff;
    logic [NG:0]      c1;
    logic [NG-1:0]    p1, g1;
    logic [HALF-1:0]  lo_sum;

    logic             s1_valid_q, s1_valid_d;
    logic [HALF-1:0]  lo_q, ahi_q, bhi_q;
    logic             clo_q;
    op_e              op_q;

    logic [NG:0]      c2;
    logic [NG-1:0]    p2, g2;
    logic [HALF-1:0]  hi_sum;
    logic [WIDTH-1:0] raw;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovfl_q, ovfl_d, sat_q, sat_d;
    logic             zero_q, neg_q;

    logic             s2_adv, s1_adv, accept, load_s2;

    assign op_in  = op_e'(op);
    assign sub_in = (op_in == SUB) || (op_in == SSUB);
    assign b_eff  = sub_in ? ~b : b;

    for (genvar k = 0; k < NG; k++) begin : g_lo
        cla_group #(.GROUP(GROUP)) u_cla (
            .a_i  (a[k*GROUP +: GROUP]),
            .b_i  (b_eff[k*GROUP +: GROUP]),
            .cin_i(c1[k]),
            .sum_o(lo_sum[k*GROUP +: GROUP]),
            .p_o  (p1[k]),
            .g_o  (g1[k])
        );
    end

    for (genvar k = 0; k < NG; k++) begin : g_hi
        cla_group #(.GROUP(GROUP)) u_cla (
            .a_i  (ahi_q[k*GROUP +: GROUP]),
            .b_i  (bhi_q[k*GROUP +: GROUP]),
            .cin_i(c2[k]),
            .sum_o(hi_sum[k*GROUP +: GROUP]),
            .p_o  (p2[k]),
            .g_o  (g2[k])
        );
    end

    always_comb begin
        c1 = '0;
        c1[0] = sub_in ? 1'b1 : cin;
        for (int unsigned k = 0; k < NG; k++) begin
            c1[k+1] = g1[k] | (p1[k] & c1[k]);
        end
        c2 = '0;
        c2[0] = clo_q;
        for (int unsigned k = 0; k < NG; k++) begin
            c2[k+1] = g2[k] | (p2[k] & c2[k]);
        end
    end

`ifdef PIPELINED_ADDSUB_SAT_EN
    localparam logic [MAX_W-1:0] POS_FULL = MAX_POS(WIDTH);
    localparam logic [MAX_W-1:0] NEG_FULL = MAX_NEG(WIDTH);
    localparam logic [WIDTH-1:0] SAT_POS  = POS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_NEG  = NEG_FULL[WIDTH-1:0];
`endif

    always_comb begin
        raw    = {hi_sum, lo_q};
        cout_d = c2[NG];
        ovfl_d = (ahi_q[HALF-1] ~^ bhi_q[HALF-1]) & (raw[WIDTH-1] ^ ahi_q[HALF-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
        sat_d  = ovfl_d & ((op_q == SADD) || (op_q == SSUB));
        sum_d  = sat_d ? (ahi_q[HALF-1] ? SAT_NEG : SAT_POS) : raw;
`else
        sat_d  = 1'b0;
        sum_d  = raw;
`endif
    end

    // S1 may move forward whenever S2 is empty or handing its beat off this edge.
    assign s2_adv     = ~s2_valid_q | out_ready;
    assign s1_adv     = s2_adv;
    assign in_ready   = ~s1_valid_q | s1_adv;
    assign accept     = in_valid & in_ready;
    assign load_s2    = s2_adv & s1_valid_q;
    assign s1_valid_d = accept | (s1_valid_q & ~s1_adv);
    assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            lo_q       <= '0;
            clo_q      <= 1'b0;
            ahi_q      <= '0;
            bhi_q      <= '0;
            op_q       <= ADD;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                lo_q  <= lo_sum;
                clo_q <= c1[NG];
                ahi_q <= a[WIDTH-1:HALF];
                bhi_q <= b_eff[WIDTH-1:HALF];
                op_q  <= op_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovfl_q     <= 1'b0;
            sat_q      <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (load_s2) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovfl_q <= ovfl_d;
                sat_q  <= sat_d;
                zero_q <= (sum_d == '0);
                neg_q  <= sum_d[WIDTH-1];
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovfl      = ovfl_q;
    assign sat       = sat_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=16, GROUP=4); expectations
// follow PIPELINED_ADDSUB_SAT_EN when it is defined for the build.
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout, ovfl, sat, zero, neg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(16), .GROUP(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovfl     (ovfl),
        .sat      (sat),
        .zero     (zero),
        .neg      (neg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] flags();
        return {cout, ovfl, sat, zero, neg};
    endfunction

    // Flags are packed {cout, ovfl, sat, zero, neg}. Entered and left at posedge+1.
    task automatic run_vec(input string tag, input logic [1:0] op_v, input logic [15:0] a_v,
                           input logic [15:0] b_v, input logic cin_v,
                           input logic [15:0] exp_sum, input logic [4:0] exp_fl);
        in_valid  = 1'b1;
        op        = op_v;
        a         = a_v;
        b         = b_v;
        cin       = cin_v;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_flags"}, 32'(flags()), 32'(exp_fl));
        @(posedge clk); #1;
    endtask

    logic [15:0] exp_q[$];
    logic [15:0] exp_v, hold_sum;
    int          sent, recvd, ghost;
    bit          prev_stall, saw_drop;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_flags", 32'(flags()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        run_vec("add_cross", 2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 5'b00000);
        run_vec("add_ovfl", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01001);
`ifdef PIPELINED_ADDSUB_SAT_EN
        run_vec("sadd_pos", 2'b10, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 5'b01100);
        run_vec("ssub_neg", 2'b11, 16'h8000, 16'h0001, 1'b1, 16'h8000, 5'b11101);
        run_vec("sadd_neg", 2'b10, 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 5'b11101);
`else
        run_vec("sadd_pos", 2'b10, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01001);
        run_vec("ssub_neg", 2'b11, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 5'b11000);
        run_vec("sadd_neg", 2'b10, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 5'b11000);
`endif
        run_vec("sub_borrow", 2'b01, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 5'b00001);
        run_vec("sub_equal", 2'b01, 16'h1234, 16'h1234, 1'b0, 16'h0000, 5'b10010);
        run_vec("add_cin", 2'b00, 16'h8000, 16'h8000, 1'b1, 16'h0001, 5'b11000);
        run_vec("sub_nocin", 2'b01, 16'h0005, 16'h0003, 1'b0, 16'h0002, 5'b10000);
        run_vec("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b10010);

        // Streaming with a 3-cycle consumer stall.
        sent       = 0;
        recvd      = 0;
        prev_stall = 1'b0;
        saw_drop   = 1'b0;
        hold_sum   = '0;
        for (int cyc = 0; cyc < 40 && recvd < 5; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 5);
            op        = 2'b00;
            a         = 16'(sent) * 16'h1111;
            b         = 16'h0001;
            cin       = 1'b1;
            @(negedge clk);
            if (prev_stall) chk("stall_hold", 32'(sum), 32'(hold_sum));
            prev_stall = out_valid && !out_ready;
            hold_sum   = sum;
            if (!in_ready) saw_drop = 1'b1;
            if (out_valid && out_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                chk("stream_data", 32'(sum), 32'(exp_v));
                recvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(a + 16'h0002);
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stream_count", 32'(recvd), 32'd5);
        chk("stream_ready_drop", 32'(saw_drop), 32'd1);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h0101;
        b         = 16'h0101;
        cin       = 1'b0;
        @(posedge clk); #1;
        a = 16'h0202;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_sum", 32'(sum), 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(in_ready), 32'd1);
        ghost = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) ghost++;
            @(negedge clk);
        end
        chk("rst_no_ghost", 32'(ghost), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
